// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues byte reads, buffers them in a prefetch FIFO
// and presents 1/2-byte instructions to decode with a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        TWO_B_OPC  = 4'hC
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic              mem_rd_en_a,
  input  logic [DATA_W-1:0] mem_data_a,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              dec_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic              instr_is_2b,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] byte_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] bpc_q  [FIFO_DEPTH];

  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     rd_nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     pop_n;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic              infl_q, tag_q;
  logic              epoch_q, epoch_d;

  logic              issue, push, xfer;
  logic              head_2b, valid;
  logic [DATA_W-1:0] head_op;

  assign rd_nxt  = rd_q + 1'b1;
  assign head_op = byte_q[rd_q];
  assign head_2b = head_op[DATA_W-1 -: 4] == TWO_B_OPC;
  assign valid   = head_2b ? (cnt_q >= CW'(2))
                           : (cnt_q != '0);
  assign xfer    = valid & dec_ready;

  // occupancy counts the in-flight read so the FIFO can never overflow
  assign occ   = cnt_q + CW'(infl_q);
  assign issue = rst & ~redirect
               & (occ < CW'(FIFO_DEPTH));
  assign push  = infl_q & ~redirect
               & (tag_q == epoch_q);

  assign mem_addr_a  = pc_q;
  assign mem_rd_en_a = issue;

  assign instr_valid = valid;
  assign instr       = valid ? head_op : '0;
  assign instr_is_2b = valid & head_2b;
  assign instr_pc    = valid ? bpc_q[rd_q] : '0;
  assign imm         = (valid & head_2b)
                     ? byte_q[rd_nxt] : '0;

  always_comb begin
    pop_n   = '0;
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    epoch_d = epoch_q;
    if (xfer) pop_n = head_2b ? CW'(2) : CW'(1);
    unique case (1'b1)
      redirect: begin
        pc_d    = redirect_addr;
        wr_d    = '0;
        rd_d    = '0;
        cnt_d   = '0;
        epoch_d = ~epoch_q;
      end
      default: begin
        if (issue) pc_d = pc_q + 1'b1;
        if (push)  wr_d = wr_q + 1'b1;
        rd_d  = rd_q + PW'(pop_n);
        cnt_d = cnt_q + CW'(push) - pop_n;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      infl_q   <= 1'b0;
      tag_q    <= 1'b0;
      epoch_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        byte_q[i] <= '0;
        bpc_q[i]  <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
      infl_q  <= issue;
      if (issue) begin
        tag_q    <= epoch_q;
        req_pc_q <= pc_q;
      end
      if (push) begin
        byte_q[wr_q] <= mem_data_a;
        bpc_q[wr_q]  <= req_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model, expected-instruction
// queue and a negedge monitor that pops and compares every transfer.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] imm;
    logic       b2;
    logic [7:0] pc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem_addr_a;
  logic       mem_rd_en_a;
  logic [7:0] mem_data_a = 8'h00;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       dec_ready = 1'b0;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       instr_is_2b;
  logic [7:0] instr_pc;

  logic [7:0] fe_addr;
  logic       fe_rd;
  logic [7:0] fe_data = 8'h00;
  logic       fe_valid;
  logic [7:0] fe_instr;
  logic [7:0] fe_imm;
  logic       fe_2b;
  logic [7:0] fe_pc;

  logic [7:0] mem [256];
  exp_t       exp_q [$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cyc0 = 0;
  int iss_n = 0;
  int xfer_n = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .mem_addr_a(mem_addr_a), .mem_rd_en_a(mem_rd_en_a),
    .mem_data_a(mem_data_a),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .dec_ready(dec_ready), .instr_valid(instr_valid),
    .instr(instr), .imm(imm), .instr_is_2b(instr_is_2b),
    .instr_pc(instr_pc)
  );

  instr_fetch_unit #(.RESET_PC(8'hFE)) u_fe (
    .clk(clk), .rst(rst),
    .mem_addr_a(fe_addr), .mem_rd_en_a(fe_rd),
    .mem_data_a(fe_data),
    .redirect(1'b0), .redirect_addr(8'h00),
    .dec_ready(1'b0), .instr_valid(fe_valid),
    .instr(fe_instr), .imm(fe_imm), .instr_is_2b(fe_2b),
    .instr_pc(fe_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en_a) mem_data_a <= mem[mem_addr_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (mem_rd_en_a) iss_n++;
      if (instr_valid && dec_ready) begin
        xfer_n++;
        if (xfer_n == 1) first_cyc = cyc;
        last_cyc = cyc;
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_xfer observed pc=%0h expected=none", instr_pc);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("xfer_op",  {24'h0, instr},       {24'h0, e.op});
          chk("xfer_imm", {24'h0, imm},         {24'h0, e.imm});
          chk("xfer_2b",  {31'h0, instr_is_2b}, {31'h0, e.b2});
          chk("xfer_pc",  {24'h0, instr_pc},    {24'h0, e.pc});
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    dec_ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1;
  endtask

  task automatic start(input logic rdy, input logic redir,
                       input logic [7:0] raddr);
    @(posedge clk); #1;
    rst = 1'b1;
    dec_ready = rdy;
    redirect = redir;
    redirect_addr = raddr;
    cyc0 = cyc;
    iss_n = 0;
    xfer_n = 0;
  endtask

  task automatic push_exp(input logic [7:0] op, input logic [7:0] im,
                          input logic b2, input logic [7:0] pc);
    exp_t e;
    e.op = op; e.imm = im; e.b2 = b2; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    dec_ready = 1'b0;
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // reset state
    do_reset();
    #2;
    chk("rst_valid", {31'h0, instr_valid}, 0);
    chk("rst_rd_en", {31'h0, mem_rd_en_a}, 0);
    chk("rst_instr", {24'h0, instr}, 0);
    chk("rst_imm",   {24'h0, imm}, 0);
    chk("rst_2b",    {31'h0, instr_is_2b}, 0);
    chk("rst_pc",    {24'h0, instr_pc}, 0);

    // T1: 1-byte stream and first-valid latency
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
    push_exp(8'h11, 8'h00, 1'b0, 8'h00);
    push_exp(8'h22, 8'h00, 1'b0, 8'h01);
    push_exp(8'h33, 8'h00, 1'b0, 8'h02);
    start(1'b1, 1'b0, 8'h00);
    #1;
    chk("t1_addr0", {24'h0, mem_addr_a}, 32'h00);
    chk("t1_rden0", {31'h0, mem_rd_en_a}, 1);
    chk("fe_addr0", {24'h0, fe_addr}, 32'hFE);
    chk("fe_rden0", {31'h0, fe_rd}, 1);
    @(posedge clk); #1;
    chk("t1_valid_e0", {31'h0, instr_valid}, 0);
    @(posedge clk); #1;
    chk("t1_valid_e1", {31'h0, instr_valid}, 1);
    drain("t1_drain");
    chk("t1_first_cyc", first_cyc - cyc0, 2);
    chk("t1_consec", last_cyc - first_cyc, 2);

    // T2: 2-byte instruction
    do_reset();
    mem[8'h00] = 8'hC1; mem[8'h01] = 8'h5A; mem[8'h02] = 8'h12;
    push_exp(8'hC1, 8'h5A, 1'b1, 8'h00);
    push_exp(8'h12, 8'h00, 1'b0, 8'h02);
    start(1'b1, 1'b0, 8'h00);
    drain("t2_drain");

    // T3: backpressure
    do_reset();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    push_exp(8'h11, 8'h00, 1'b0, 8'h00);
    push_exp(8'h22, 8'h00, 1'b0, 8'h01);
    push_exp(8'h33, 8'h00, 1'b0, 8'h02);
    push_exp(8'h44, 8'h00, 1'b0, 8'h03);
    start(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_instr", {24'h0, instr}, 32'h11);
    end
    chk("t3_hold_valid", {31'h0, instr_valid}, 1);
    chk("t3_issues", iss_n, 4);
    chk("t3_full_rden", {31'h0, mem_rd_en_a}, 0);
    dec_ready = 1'b1;
    drain("t3_drain");

    // T4: redirect while read of 03 is in flight
    do_reset();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    mem[8'h40] = 8'hA5; mem[8'h41] = 8'hB6;
    push_exp(8'h11, 8'h00, 1'b0, 8'h00);
    push_exp(8'hA5, 8'h00, 1'b0, 8'h40);
    push_exp(8'hB6, 8'h00, 1'b0, 8'h41);
    start(1'b0, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_addr = 8'h40;
    dec_ready = 1'b1;
    #1;
    chk("t4_redir_rden", {31'h0, mem_rd_en_a}, 0);
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("t4_post_valid", {31'h0, instr_valid}, 0);
    #1;
    chk("t4_resume_addr", {24'h0, mem_addr_a}, 32'h40);
    drain("t4_drain");

    // T5: split 2-byte instruction across address wrap
    do_reset();
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'hC2; mem[8'h00] = 8'h77;
    push_exp(8'h01, 8'h00, 1'b0, 8'hFE);
    push_exp(8'hC2, 8'h77, 1'b1, 8'hFF);
    start(1'b1, 1'b1, 8'hFE);
    @(posedge clk); #1;
    redirect = 1'b0;
    drain("t5_drain");

    // T6: async reset with three buffered entries
    do_reset();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22;
    start(1'b0, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_valid", {31'h0, instr_valid}, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, instr_valid}, 0);
    chk("t6_rst_rden", {31'h0, mem_rd_en_a}, 0);
    chk("t6_rst_instr", {24'h0, instr}, 0);
    push_exp(8'h11, 8'h00, 1'b0, 8'h00);
    push_exp(8'h22, 8'h00, 1'b0, 8'h01);
    start(1'b1, 1'b0, 8'h00);
    #1;
    chk("t6_refetch_addr", {24'h0, mem_addr_a}, 32'h00);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
